// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle datapath controller: FSM states, opcode/funct
// values and the mux-select / ALU-operation codes driven onto the datapath.
package ctrl_pkg;

    // ADDI execute and load/store address generation drive identical controls, so
    // they share StImmEx; this keeps the state space within 4 bits.
    typedef enum logic [3:0] {
        StRst,
        StFetch,
        StMemwF,
        StDecode,
        StREx,
        StRWb,
        StImmEx,
        StIWb,
        StLuiWb,
        StMemwL,
        StLwWb,
        StMemwS,
        StBeq,
        StJmp,
        StJal,
        StExc
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLui   = 6'h0F;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnSlt = 6'h2A;

    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluSlt = 3'd3;

    localparam logic [1:0] PcSrcAlu    = 2'd0;
    localparam logic [1:0] PcSrcAluOut = 2'd1;
    localparam logic [1:0] PcSrcJump   = 2'd2;

    localparam logic [1:0] AsbReg    = 2'd0;
    localparam logic [1:0] AsbFour   = 2'd1;
    localparam logic [1:0] AsbImm    = 2'd2;
    localparam logic [1:0] AsbImmSh2 = 2'd3;

    localparam logic [2:0] WdAluOut = 3'b000;
    localparam logic [2:0] WdMdr    = 3'b001;
    localparam logic [2:0] WdLui    = 3'b010;
    localparam logic [2:0] WdPc     = 3'b011;

    localparam logic [1:0] RegDstRt = 2'd0;
    localparam logic [1:0] RegDstRd = 2'd1;
    localparam logic [1:0] RegDstRa = 2'd2;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) || (funct == FnSlt);
    endfunction

    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        logic [2:0] op;
        case (funct)
            FnSub:   op = AluSub;
            FnAnd:   op = AluAnd;
            FnSlt:   op = AluSlt;
            default: op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory wait-state counter: loads the latency, counts down to zero and holds there.
module mem_wait_cnt (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_load,
    input  logic [2:0] i_load_val,
    output logic [2:0] o_cnt,
    output logic       o_last
);

    logic [2:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == 3'd1);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore controller for the multicycle 32-bit datapath: every select and write enable
// is decoded from the state register (plus funct in R_EX).
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT     = 1,
    parameter logic [1:0]  EXC_VEC_SEL = 2'd3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [2:0] wd_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       epc_write,
    output logic [3:0] state_o
);

    localparam logic [2:0] LatCnt = 3'(MEM_LAT);

    state_e     r_state;
    state_e     w_state_next;
    logic       w_cnt_load;
    logic       w_cnt_last;
    logic [2:0] w_cnt;
    // Branch qualification by zero happens in the PC write-enable logic of the datapath.
    logic       w_unused_zero;

    assign w_unused_zero = zero;

    mem_wait_cnt u_wait_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (LatCnt),
        .o_cnt      (w_cnt),
        .o_last     (w_cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StRst;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_load    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PcSrcAlu;
        iord          = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = RegDstRt;
        wd_sel        = WdAluOut;
        alu_src_a     = 1'b0;
        alu_src_b     = AsbReg;
        alu_op        = AluAdd;
        epc_write     = 1'b0;

        case (r_state)
            StRst: w_state_next = StFetch;
            StFetch: begin
                alu_src_b    = AsbFour;
                pc_write     = 1'b1;
                w_cnt_load   = 1'b1;
                w_state_next = StMemwF;
            end
            StMemwF: begin
                if (w_cnt_last) begin
                    ir_write     = 1'b1;
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                alu_src_b = AsbImmSh2;
                case (opcode)
                    OpRtype:    w_state_next = StREx;
                    OpAddi:     w_state_next = StImmEx;
                    OpLui:      w_state_next = StLuiWb;
                    OpLw, OpSw: w_state_next = StImmEx;
                    OpBeq:      w_state_next = StBeq;
                    OpJ:        w_state_next = StJmp;
                    OpJal:      w_state_next = StJal;
                    default:    w_state_next = StExc;
                endcase
            end
            StREx: begin
                alu_src_a    = 1'b1;
                alu_op       = funct_alu_op(funct);
                w_state_next = funct_legal(funct) ? StRWb : StExc;
            end
            StRWb: begin
                reg_write    = 1'b1;
                reg_dst      = RegDstRd;
                w_state_next = StFetch;
            end
            StImmEx: begin
                alu_src_a  = 1'b1;
                alu_src_b  = AsbImm;
                w_cnt_load = 1'b1;
                if (opcode == OpLw) begin
                    w_state_next = StMemwL;
                end else if (opcode == OpSw) begin
                    w_state_next = StMemwS;
                end else begin
                    w_state_next = StIWb;
                end
            end
            StIWb: begin
                reg_write    = 1'b1;
                w_state_next = StFetch;
            end
            StLuiWb: begin
                reg_write    = 1'b1;
                wd_sel       = WdLui;
                w_state_next = StFetch;
            end
            StMemwL: begin
                iord = 1'b1;
                if (w_cnt_last) begin
                    mdr_write    = 1'b1;
                    w_state_next = StLwWb;
                end
            end
            StLwWb: begin
                reg_write    = 1'b1;
                wd_sel       = WdMdr;
                w_state_next = StFetch;
            end
            StMemwS: begin
                iord   = 1'b1;
                // Only the first wait cycle writes, so a store is exactly one write pulse.
                mem_wr = (w_cnt == LatCnt);
                if (w_cnt_last) begin
                    w_state_next = StFetch;
                end
            end
            StBeq: begin
                alu_src_a     = 1'b1;
                alu_op        = AluSub;
                pc_write_cond = 1'b1;
                pc_src        = PcSrcAluOut;
                w_state_next  = StFetch;
            end
            StJmp: begin
                pc_write     = 1'b1;
                pc_src       = PcSrcJump;
                w_state_next = StFetch;
            end
            StJal: begin
                reg_write    = 1'b1;
                reg_dst      = RegDstRa;
                wd_sel       = WdPc;
                pc_write     = 1'b1;
                pc_src       = PcSrcJump;
                w_state_next = StFetch;
            end
            StExc: begin
                epc_write    = 1'b1;
                pc_write     = 1'b1;
                pc_src       = EXC_VEC_SEL;
                w_state_next = StFetch;
            end
            default: w_state_next = StRst;
        endcase
    end

    assign state_o = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three instances (MEM_LAT 1..3) checked cycle by cycle
// against a per-instruction expected-output sequence plus hand-computed literals.
module tb_multicycle_ctrl;
    import ctrl_pkg::*;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [2:0] wd_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       epc_write;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  is_rst;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n [3];
    logic [5:0] opc   [3];
    logic [5:0] fun   [3];
    logic       zr    [3];
    outs_t      outs  [3];
    logic [3:0] st    [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pw, pwc, io, mw, irw, mdw, rw, asa, epw;
        logic [1:0] ps, rd, asb;
        logic [2:0] wd, aop;
        logic [3:0] s;

        multicycle_ctrl #(
            .MEM_LAT     (g + 1),
            .EXC_VEC_SEL (2'd3)
        ) u_dut (
            .clk           (clk),
            .reset_n       (rst_n[g]),
            .opcode        (opc[g]),
            .funct         (fun[g]),
            .zero          (zr[g]),
            .pc_write      (pw),
            .pc_write_cond (pwc),
            .pc_src        (ps),
            .iord          (io),
            .mem_wr        (mw),
            .ir_write      (irw),
            .mdr_write     (mdw),
            .reg_write     (rw),
            .reg_dst       (rd),
            .wd_sel        (wd),
            .alu_src_a     (asa),
            .alu_src_b     (asb),
            .alu_op        (aop),
            .epc_write     (epw),
            .state_o       (s)
        );

        assign outs[g] = {pw, pwc, ps, io, mw, irw, mdw, rw, rd, wd, asa, asb, aop, epw};
        assign st[g]   = s;
    end

    int    checks   = 0;
    int    failures = 0;
    int    act      = 0;
    exp_t  exp_q [$];
    outs_t mq [$];
    int    cyc, first_ir, first_rw, first_mdr;
    int    n_mw, n_mdr, n_rw, n_epc, n_pwc;
    bit    mw_iord_ok;

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic outs_t wb(input logic [1:0] rd, input logic [2:0] wd);
        outs_t o = '0;
        o.reg_write = 1'b1;
        o.reg_dst   = rd;
        o.wd_sel    = wd;
        return o;
    endfunction

    function automatic outs_t exc_o();
        outs_t o = '0;
        o.epc_write = 1'b1;
        o.pc_write  = 1'b1;
        o.pc_src    = 2'd3;
        return o;
    endfunction

    // Expected outputs, one entry per cycle from FETCH to the last state of the instruction.
    function automatic void build(input logic [5:0] op, input logic [5:0] fn, input int lat);
        outs_t o;
        o = '0; o.pc_write = 1'b1; o.alu_src_b = 2'd1; mq.push_back(o);
        for (int i = 1; i <= lat; i++) begin
            o = '0; o.ir_write = (i == lat); mq.push_back(o);
        end
        o = '0; o.alu_src_b = 2'd3; mq.push_back(o);
        o = '0;
        case (op)
            6'h00: begin
                o.alu_src_a = 1'b1;
                case (fn)
                    6'h22:   o.alu_op = 3'd1;
                    6'h24:   o.alu_op = 3'd2;
                    6'h2A:   o.alu_op = 3'd3;
                    default: o.alu_op = 3'd0;
                endcase
                mq.push_back(o);
                if (fn inside {6'h20, 6'h22, 6'h24, 6'h2A}) mq.push_back(wb(2'd1, 3'b000));
                else mq.push_back(exc_o());
            end
            6'h08: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; mq.push_back(o);
                mq.push_back(wb(2'd0, 3'b000));
            end
            6'h0F: mq.push_back(wb(2'd0, 3'b010));
            6'h23, 6'h2B: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; mq.push_back(o);
                for (int i = 1; i <= lat; i++) begin
                    o = '0; o.iord = 1'b1;
                    if (op == 6'h23) o.mdr_write = (i == lat);
                    else o.mem_wr = (i == 1);
                    mq.push_back(o);
                end
                if (op == 6'h23) mq.push_back(wb(2'd0, 3'b001));
            end
            6'h04: begin
                o.alu_src_a = 1'b1; o.alu_op = 3'd1; o.pc_write_cond = 1'b1; o.pc_src = 2'd1;
                mq.push_back(o);
            end
            6'h02: begin
                o.pc_write = 1'b1; o.pc_src = 2'd2; mq.push_back(o);
            end
            6'h03: begin
                o = wb(2'd2, 3'b011); o.pc_write = 1'b1; o.pc_src = 2'd2; mq.push_back(o);
            end
            default: mq.push_back(exc_o());
        endcase
    endfunction

    task automatic compare_loop();
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (outs[k].wd_sel == 3'b100) begin
                    failures++;
                    $display("FAIL wd_sel_rsvd dut%0d: got %b, required not 100", k, outs[k].wd_sel);
                end
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc++;
                checks++;
                if (outs[act] !== e.o) begin
                    failures++;
                    $display("FAIL outputs dut%0d cycle %0d: got %h, required %h",
                             act, cyc, outs[act], e.o);
                end
                if (e.is_rst) begin
                    checks++;
                    if (st[act] !== 4'(StRst)) begin
                        failures++;
                        $display("FAIL reset_state dut%0d: got %0d, required %0d",
                                 act, st[act], StRst);
                    end
                end
                if (outs[act].ir_write && first_ir < 0) first_ir = cyc;
                if (outs[act].reg_write && first_rw < 0) first_rw = cyc;
                if (outs[act].mdr_write && first_mdr < 0) first_mdr = cyc;
                if (outs[act].mem_wr) begin
                    n_mw++;
                    if (!outs[act].iord) mw_iord_ok = 1'b0;
                end
                if (outs[act].mdr_write) n_mdr++;
                if (outs[act].reg_write) n_rw++;
                if (outs[act].epc_write) n_epc++;
                if (outs[act].pc_write_cond) n_pwc++;
            end
        end
    endtask

    // Caller guarantees instance k enters FETCH on the next rising edge.
    task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int cut, input int exp_len);
        int   n;
        exp_t e;
        act = k; opc[k] = op; fun[k] = fn; zr[k] = z;
        cyc = 0; first_ir = -1; first_rw = -1; first_mdr = -1;
        n_mw = 0; n_mdr = 0; n_rw = 0; n_epc = 0; n_pwc = 0; mw_iord_ok = 1'b1;
        mq.delete();
        build(op, fn, k + 1);
        if (exp_len > 0) chk("model_len", mq.size(), exp_len);
        n = (cut > 0) ? cut : mq.size();
        for (int i = 0; i < n; i++) begin
            e.o = mq[i]; e.is_rst = 1'b0; exp_q.push_back(e);
        end
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic hold_reset(input int k, input int n);
        exp_t e;
        act = k; rst_n[k] = 1'b0;
        e.o = '0; e.is_rst = 1'b1;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic release_rst(input int k);
        @(negedge clk);
        rst_n[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0; opc[k] = 6'h23; fun[k] = 6'h00; zr[k] = 1'b0;
        end
        fork
            compare_loop();
        join_none

        // MEM_LAT = 1
        hold_reset(0, 3);
        release_rst(0);
        run_instr(0, 6'h00, 6'h20, 1'b0, 0, 5);
        chk("radd_ir_write_cycle", first_ir, 2);
        chk("radd_reg_write_cycle", first_rw, 5);
        run_instr(0, 6'h00, 6'h22, 1'b0, 0, 5);
        run_instr(0, 6'h00, 6'h24, 1'b0, 0, 5);
        run_instr(0, 6'h00, 6'h2A, 1'b0, 0, 5);
        run_instr(0, 6'h08, 6'h00, 1'b0, 0, 5);
        run_instr(0, 6'h0F, 6'h00, 1'b0, 0, 4);
        run_instr(0, 6'h23, 6'h00, 1'b0, 0, 6);
        run_instr(0, 6'h2B, 6'h00, 1'b0, 0, 5);
        chk("sw1_mem_wr_count", n_mw, 1);
        run_instr(0, 6'h04, 6'h00, 1'b0, 0, 4);
        chk("beq_z0_pwc_count", n_pwc, 1);
        run_instr(0, 6'h04, 6'h00, 1'b1, 0, 4);
        chk("beq_z1_pwc_count", n_pwc, 1);
        run_instr(0, 6'h02, 6'h00, 1'b0, 0, 4);
        run_instr(0, 6'h03, 6'h00, 1'b0, 0, 4);
        chk("jal_reg_write_cycle", first_rw, 4);
        run_instr(0, 6'h3F, 6'h00, 1'b0, 0, 4);
        chk("illegal_op_epc_count", n_epc, 1);
        chk("illegal_op_reg_write", n_rw, 0);
        run_instr(0, 6'h00, 6'h01, 1'b0, 0, 5);
        chk("bad_funct_epc_count", n_epc, 1);
        chk("bad_funct_reg_write", n_rw, 0);

        // MEM_LAT = 2
        release_rst(1);
        run_instr(1, 6'h2B, 6'h00, 1'b0, 0, 7);
        chk("sw2_mem_wr_count", n_mw, 1);
        chk("sw2_mem_wr_iord", int'(mw_iord_ok), 1);
        chk("sw2_reg_write", n_rw, 0);
        run_instr(1, 6'h23, 6'h00, 1'b0, 0, 8);

        // MEM_LAT = 3
        release_rst(2);
        run_instr(2, 6'h23, 6'h00, 1'b0, 0, 10);
        chk("lw3_mdr_count", n_mdr, 1);
        chk("lw3_mdr_cycle", first_mdr, 9);
        chk("lw3_reg_write_cycle", first_rw, 10);
        // Abort in the first MEMW_L cycle (7th cycle of lw at MEM_LAT = 3).
        run_instr(2, 6'h23, 6'h00, 1'b0, 7, 10);
        chk("abort_pre_iord", int'(outs[2].iord), 1);
        rst_n[2] = 1'b0;
        #1;
        chk("abort_async_outputs", int'(outs[2]), 0);
        chk("abort_async_state", int'(st[2]), int'(StRst));
        n_rw = 0;
        hold_reset(2, 2);
        chk("abort_no_reg_write", n_rw, 0);
        release_rst(2);
        run_instr(2, 6'h23, 6'h00, 1'b0, 0, 10);
        chk("recover_mdr_count", n_mdr, 1);
        run_instr(2, 6'h2B, 6'h00, 1'b0, 0, 9);
        chk("sw3_mem_wr_count", n_mw, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
